lcd_hd44780_resp: RTL and testbench
===================================

# lcd_hd44780_resp

Synthesizable HD44780-compatible responder for the 8-bit LCD bus, i.e. the display end of the bus our LCD driver blocks control. It decodes E/RS/RW/DB strobes, executes the DDRAM-relevant instruction subset, holds a 128-byte DDRAM, and answers busy-flag and data reads. Other on-chip logic and the verification bench can read DDRAM through a peek port. It replaces the physical panel in simulation and in on-FPGA loopback tests.

## Interface
- BUSY_CYCLES, 40: busy duration after a normal instruction or data write (40 µs at 1 MHz).
- CLEAR_CYCLES, 1640: busy duration after clear display or return home; effective value is max(CLEAR_CYCLES, 128).
- POR_CYCLES, 200: busy duration after reset; effective value is max(POR_CYCLES, 128).
- CLK_1MHZ  in  1  system clock; all bus inputs are synchronous to it.
- RST  in  1  asynchronous, active-low reset.
- LCD_E, LCD_RS, LCD_RW  in  1 each  bus strobes from the driver.
- LCD_DB  in  8  write data from the driver.
- DB_OUT  out  8  read data; combinational.
- DB_OE  out  1  LCD_E & LCD_RW; enables the read-back tristate at the top level.
- BF  out  1  busy flag; equals DB_OUT[7] during status reads.
- AC  out  7  address counter.
- DISP_CTRL  out  3  {D, C, B} from display on/off control.
- ENTRY  out  2  {I/D, S}.
- FUNC  out  3  {DL, N, F}.
- PEEK_ADDR  in  7  debug DDRAM address.
- PEEK_DATA  out  8  DDRAM[PEEK_ADDR]; combinational.
- ERR  out  1  sticky flag: a write strobe arrived while BF=1. Cleared only by reset.
- WR_STB  out  1  one-cycle pulse for each accepted write.

## Operation
- The block registers LCD_E into e_d. A strobe is e_d=1 & LCD_E=0 (falling edge). LCD_RS, LCD_RW and LCD_DB are sampled in the strobe cycle.
- Write strobe (RW=0) while BF=1: ignored, ERR set, no state change.
- Write strobe with BF=0 and RS=1 (data): DDRAM[AC] ← DB. AC increments if I/D=1, else decrements, modulo 128. BF is then held for BUSY_CYCLES.
- Write strobe with BF=0 and RS=0 decodes on the highest set bit of DB:
  - 1aaaaaaa: AC ← aaaaaaa.
  - 01xxxxxx (CGRAM address): accepted, busy applied, no other effect.
  - 001 DL N F xx: FUNC ← {DL, N, F}.
  - 0001 S/C R/L xx: if S/C=0, AC ±1 (R/L=1 increments); if S/C=1, no effect.
  - 00001 D C B: DISP_CTRL ← {D, C, B}.
  - 000001 I/D S: ENTRY ← {I/D, S}.
  - 0000001x (return home): AC ← 0, long busy.
  - 00000001 (clear display): enter FILL, AC ← 0, I/D ← 1, long busy.
  - 00000000: no effect, normal busy.
- Read strobe (RW=1) is accepted regardless of BF and never sets ERR.
  - RS=1: AC advances per I/D at the strobe.
  - RS=0: no state change.
- DB_OUT is {BF, AC} when RS=0 and DDRAM[AC] when RS=1. It must be valid in the same cycle the RS/RW inputs change, with no register stage.
- State machine:
  - IDLE: BF=0; strobes are processed as above.
  - BUSY: BF=1; counter counts down to 0, then returns to IDLE.
  - FILL: BF=1; writes 0x20 to DDRAM[fill_cnt], one address per cycle, for 0..127. Then moves to BUSY with the remaining count (total length = effective long busy).
- Busy counter is 16 bits wide. Parameters above 65535 are illegal.

## Timing
- Reset values: AC=0, DISP_CTRL=0, ENTRY=2'b10, FUNC=3'b100, ERR=0, WR_STB=0, e_d=0, BF=1, state=FILL. The POR fill sets every DDRAM location to 0x20.
- Command execution: AC and the config registers update on the clock edge of the strobe cycle. BF rises on that same edge. WR_STB is high for that one cycle.
- BF stays high for exactly N cycles after the strobe edge, where N = BUSY_CYCLES, or the effective long value for clear and home.
- A strobe in the same cycle BF falls is seen as busy and sets ERR.
- Reset asserted mid-FILL or mid-BUSY aborts immediately. Fill restarts from address 0 after reset release.
- E held high for any number of cycles gives exactly one strobe.
- A one-cycle E pulse is a valid strobe.

## Test plan
- Reset, then poll status (RS=0, RW=1, E=1) → BF=1 for 200 cycles, then DB_OUT=0x00. PEEK over all 128 addresses returns 0x20.
- Write 0x3C, 0x0C, 0x06, 0x80 (polling BF between each), then data 0x41, 0x42 → PEEK[0]=0x41, PEEK[1]=0x42, AC=2, FUNC=3'b111, DISP_CTRL=3'b100.
- Data write, then a second write 10 cycles later → second write ignored, ERR=1, DDRAM unchanged. Status read in the same window returns BF=1.
- Write 0xFF (AC=0x7F), then data 0x55 → AC wraps to 0x00. Set entry 0x04, then data write → AC=0x7F.
- Write clear 0x01 → BF high for 1640 cycles, all DDRAM=0x20, AC=0, ENTRY[1]=1.
- Assert RST 50 cycles into a clear → all outputs return to reset values asynchronously, and the POR fill reruns.

Source files
------------

// File: rtl/lcd_hd44780_resp.sv
// HD44780-compatible display-side responder for the 8-bit LCD bus.
// Decodes E falling-edge strobes, executes the DDRAM instruction subset and answers reads.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | BF=0, strobes executed
// BUSY   | BF=1, busy counter running down to 0
// FILL   | BF=1, writing 0x20 across DDRAM, then BUSY for the rest of the long busy
module lcd_hd44780_resp #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1640,
    parameter int POR_CYCLES   = 200
) (
    input  logic       i_clk_1mhz,
    input  logic       i_rst_n,
    input  logic       i_lcd_e,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic [7:0] i_lcd_db,
    output logic [7:0] o_db_out,
    output logic       o_db_oe,
    output logic       o_bf,
    output logic [6:0] o_ac,
    output logic [2:0] o_disp_ctrl,
    output logic [1:0] o_entry,
    output logic [2:0] o_func,
    input  logic [6:0] i_peek_addr,
    output logic [7:0] o_peek_data,
    output logic       o_err,
    output logic       o_wr_stb
);

    localparam int CLR_EFF = (CLEAR_CYCLES > 128) ? CLEAR_CYCLES : 128;
    localparam int POR_EFF = (POR_CYCLES > 128) ? POR_CYCLES : 128;

    // Counter loads are "cycles minus one" so the terminal compare is against zero.
    localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] HOME_LOAD = 16'(CLR_EFF - 1);
    localparam logic [15:0] CLR_REM   = 16'(CLR_EFF - 128);
    localparam logic [15:0] POR_REM   = 16'(POR_EFF - 128);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_busy_cnt;
    logic [6:0]  r_fill_cnt;
    logic        r_e_d;
    logic [6:0]  r_ac;
    logic [2:0]  r_disp;
    logic [1:0]  r_entry;
    logic [2:0]  r_func;
    logic        r_err;
    logic        r_wr_stb;
    logic [7:0]  r_mem [128];

    logic       w_strobe;
    logic       w_bf;
    logic       w_wr;
    logic       w_wr_ok;
    logic       w_rd_data;
    logic [6:0] w_ac_step;
    logic [6:0] w_ac_nxt;
    logic [2:0] w_disp_nxt;
    logic [1:0] w_entry_nxt;
    logic [2:0] w_func_nxt;
    logic       w_is_home;
    logic       w_is_clear;

    assign w_strobe  = r_e_d & ~i_lcd_e;
    assign w_bf      = (r_state != S_IDLE);
    assign w_wr      = w_strobe & ~i_lcd_rw;
    assign w_wr_ok   = w_wr & ~w_bf;
    assign w_rd_data = w_strobe & i_lcd_rw & i_lcd_rs;
    assign w_ac_step = r_entry[1] ? (r_ac + 7'd1) : (r_ac - 7'd1);

    always_comb begin
        w_ac_nxt    = r_ac;
        w_disp_nxt  = r_disp;
        w_entry_nxt = r_entry;
        w_func_nxt  = r_func;
        w_is_home   = 1'b0;
        w_is_clear  = 1'b0;
        if (i_lcd_rs) begin
            w_ac_nxt = w_ac_step;
        end else begin
            casez (i_lcd_db)
                8'b1???????: w_ac_nxt = i_lcd_db[6:0];
                8'b01??????: ;
                8'b001?????: w_func_nxt = i_lcd_db[4:2];
                8'b0001????: begin
                    if (!i_lcd_db[3])
                        w_ac_nxt = i_lcd_db[2] ? (r_ac + 7'd1) : (r_ac - 7'd1);
                end
                8'b00001???: w_disp_nxt = i_lcd_db[2:0];
                8'b000001??: w_entry_nxt = i_lcd_db[1:0];
                8'b0000001?: begin
                    w_ac_nxt  = 7'd0;
                    w_is_home = 1'b1;
                end
                8'b00000001: begin
                    w_ac_nxt       = 7'd0;
                    w_entry_nxt[1] = 1'b1;
                    w_is_clear     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk_1mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_FILL;
            r_busy_cnt <= POR_REM;
            r_fill_cnt <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_ok) begin
                        if (!i_lcd_rs && w_is_clear) begin
                            r_state    <= S_FILL;
                            r_fill_cnt <= 7'd0;
                            r_busy_cnt <= CLR_REM;
                        end else if (!i_lcd_rs && w_is_home) begin
                            r_state    <= S_BUSY;
                            r_busy_cnt <= HOME_LOAD;
                        end else begin
                            r_state    <= S_BUSY;
                            r_busy_cnt <= BUSY_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_busy_cnt == 16'd0)
                        r_state <= S_IDLE;
                    else
                        r_busy_cnt <= r_busy_cnt - 16'd1;
                end
                S_FILL: begin
                    r_fill_cnt <= r_fill_cnt + 7'd1;
                    if (r_fill_cnt == 7'd127) begin
                        if (r_busy_cnt == 16'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_BUSY;
                            r_busy_cnt <= r_busy_cnt - 16'd1;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk_1mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e_d    <= 1'b0;
            r_ac     <= 7'd0;
            r_disp   <= 3'd0;
            r_entry  <= 2'b10;
            r_func   <= 3'b100;
            r_err    <= 1'b0;
            r_wr_stb <= 1'b0;
        end else begin
            r_e_d    <= i_lcd_e;
            r_wr_stb <= w_wr_ok;
            if (w_wr && w_bf)
                r_err <= 1'b1;
            if (w_wr_ok) begin
                r_ac    <= w_ac_nxt;
                r_disp  <= w_disp_nxt;
                r_entry <= w_entry_nxt;
                r_func  <= w_func_nxt;
            end else if (w_rd_data) begin
                r_ac <= w_ac_step;
            end
        end
    end

    // DDRAM is not reset; the fill that follows every reset initialises it.
    always_ff @(posedge i_clk_1mhz) begin
        if (r_state == S_FILL)
            r_mem[r_fill_cnt] <= 8'h20;
        else if (w_wr_ok && i_lcd_rs)
            r_mem[r_ac] <= i_lcd_db;
    end

    assign o_db_out    = i_lcd_rs ? r_mem[r_ac] : {w_bf, r_ac};
    assign o_db_oe     = i_lcd_e & i_lcd_rw;
    assign o_bf        = w_bf;
    assign o_ac        = r_ac;
    assign o_disp_ctrl = r_disp;
    assign o_entry     = r_entry;
    assign o_func      = r_func;
    assign o_peek_data = r_mem[i_peek_addr];
    assign o_err       = r_err;
    assign o_wr_stb    = r_wr_stb;

endmodule

// File: tb/tb_lcd_hd44780_resp.sv
// Self-checking bench for lcd_hd44780_resp: directed scenarios plus randomized bus traffic
// compared against a cycle-indexed behavioural model of the display controller.
`timescale 1ns/1ps

module tb_lcd_hd44780_resp;

    localparam int P_BUSY = 40;
    localparam int P_CLR  = 1640;
    localparam int P_POR  = 200;
    localparam int LONG   = (P_CLR > 128) ? P_CLR : 128;
    localparam int PORL   = (P_POR > 128) ? P_POR : 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_db = 8'h00;
    logic [6:0] peek_addr = 7'd0;
    logic [7:0] db_out;
    logic       db_oe;
    logic       bf;
    logic [6:0] ac;
    logic [2:0] disp_ctrl;
    logic [1:0] entry;
    logic [2:0] func;
    logic [7:0] peek_data;
    logic       err;
    logic       wr_stb;

    int tests = 0;
    int fails = 0;
    int cyc;

    // Model state: BF is high in every cycle index below m_bf_end.
    logic [7:0] m_mem [128];
    int         m_ac;
    logic [1:0] m_entry;
    logic [2:0] m_func;
    logic [2:0] m_disp;
    logic       m_err;
    int         m_bf_end;

    lcd_hd44780_resp #(.BUSY_CYCLES(P_BUSY), .CLEAR_CYCLES(P_CLR), .POR_CYCLES(P_POR)) dut (
        .i_clk_1mhz (clk),
        .i_rst_n    (rst_n),
        .i_lcd_e    (lcd_e),
        .i_lcd_rs   (lcd_rs),
        .i_lcd_rw   (lcd_rw),
        .i_lcd_db   (lcd_db),
        .o_db_out   (db_out),
        .o_db_oe    (db_oe),
        .o_bf       (bf),
        .o_ac       (ac),
        .o_disp_ctrl(disp_ctrl),
        .o_entry    (entry),
        .o_func     (func),
        .i_peek_addr(peek_addr),
        .o_peek_data(peek_data),
        .o_err      (err),
        .o_wr_stb   (wr_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int step(input int a, input bit inc);
        return inc ? (a + 1) % 128 : (a + 127) % 128;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_entry = 2'b10; m_func = 3'b100; m_disp = 3'b000; m_err = 1'b0;
        m_bf_end = PORL;
    endtask

    task automatic model_write(input logic rs, input logic [7:0] db, input int cs);
        int n;
        int d;
        n = P_BUSY;
        d = int'(db);
        if (rs) begin
            m_mem[m_ac] = db;
            m_ac = step(m_ac, m_entry[1]);
        end else if (d >= 128) begin
            m_ac = d - 128;
        end else if (d >= 64) begin
            n = P_BUSY;
        end else if (d >= 32) begin
            m_func = 3'((d / 4) % 8);
        end else if (d >= 16) begin
            if ((d / 8) % 2 == 0) m_ac = step(m_ac, (d / 4) % 2 == 1);
        end else if (d >= 8) begin
            m_disp = 3'(d % 8);
        end else if (d >= 4) begin
            m_entry = 2'(d % 4);
        end else if (d >= 2) begin
            m_ac = 0;
            n = LONG;
        end else if (d == 1) begin
            for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
            m_ac = 0;
            m_entry[1] = 1'b1;
            n = LONG;
        end
        m_bf_end = cs + 1 + n;
    endtask

    task automatic do_reset();
        lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_db = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One bus access: E high for 'hold' cycles, then falls; checks read data and post-edge state.
    task automatic bus_op(input logic rs, input logic rw, input logic [7:0] db, input int hold);
        int cs;
        bit acc_wr;
        logic [7:0] exp_db;
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = rw; lcd_db = db; lcd_e = 1'b1;
        #1;
        if (rw) begin
            exp_db = rs ? m_mem[m_ac] : {(cyc < m_bf_end), 7'(m_ac)};
            tests++;
            if (db_out !== exp_db) begin
                fails++;
                $display("FAIL read_data rs=%0b: got %02h expected %02h", rs, db_out, exp_db);
            end
            tests++;
            if (db_oe !== 1'b1) begin
                fails++;
                $display("FAIL db_oe: got %0b expected 1", db_oe);
            end
        end
        repeat (hold) @(posedge clk);
        #1;
        lcd_e = 1'b0;
        cs = cyc;
        acc_wr = !rw && (cs >= m_bf_end);
        if (!rw && !acc_wr) m_err = 1'b1;
        if (acc_wr) model_write(rs, db, cs);
        if (rw && rs) m_ac = step(m_ac, m_entry[1]);
        @(posedge clk); #1;
        tests++;
        if (wr_stb !== acc_wr) begin
            fails++;
            $display("FAIL wr_stb: got %0b expected %0b", wr_stb, acc_wr);
        end
        tests++;
        if (ac !== 7'(m_ac) || bf !== (cyc < m_bf_end) || err !== m_err) begin
            fails++;
            $display("FAIL post_op ac/bf/err: got %02h/%0b/%0b expected %02h/%0b/%0b",
                     ac, bf, err, 7'(m_ac), (cyc < m_bf_end), m_err);
        end
        tests++;
        if (entry !== m_entry || func !== m_func || disp_ctrl !== m_disp) begin
            fails++;
            $display("FAIL post_op entry/func/disp: got %0h/%0h/%0h expected %0h/%0h/%0h",
                     entry, func, disp_ctrl, m_entry, m_func, m_disp);
        end
        @(posedge clk); #1;
        tests++;
        if (wr_stb !== 1'b0) begin
            fails++;
            $display("FAIL wr_stb_pulse_width: got %0b expected 0", wr_stb);
        end
    endtask

    task automatic wait_idle(input string name);
        int  k;
        bit  bad;
        int  bad_cyc;
        bad = 1'b0;
        bad_cyc = 0;
        k = 0;
        while (k < 5000) begin
            @(negedge clk);
            if (bf !== (cyc < m_bf_end) && !bad) begin
                bad = 1'b1;
                bad_cyc = cyc;
            end
            if (bf === 1'b0) break;
            k++;
        end
        tests++;
        if (bad || k >= 5000) begin
            fails++;
            $display("FAIL busy_len_%s: bf mismatch at cycle %0d (timeout=%0b), BF must fall at cycle %0d",
                     name, bad_cyc, (k >= 5000), m_bf_end);
        end
    endtask

    task automatic peek_all(input string name);
        for (int i = 0; i < 128; i++) begin
            peek_addr = 7'(i);
            #1;
            tests++;
            if (peek_data !== m_mem[i]) begin
                fails++;
                $display("FAIL peek_%s[%0d]: got %02h expected %02h", name, i, peek_data, m_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (ac !== 7'd0 || disp_ctrl !== 3'd0 || entry !== 2'b10 || func !== 3'b100 ||
            err !== 1'b0 || wr_stb !== 1'b0 || bf !== 1'b1 || db_oe !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: ac=%02h disp=%0h entry=%0h func=%0h err=%0b wr_stb=%0b bf=%0b oe=%0b",
                     ac, disp_ctrl, entry, func, err, wr_stb, bf, db_oe);
        end
    endtask

    task automatic test_por();
        wait_idle("por");
        bus_op(1'b0, 1'b1, 8'h00, 1);
        peek_all("por");
    endtask

    task automatic test_config();
        bus_op(1'b0, 1'b0, 8'h3C, 1); wait_idle("func");
        bus_op(1'b0, 1'b0, 8'h0C, 2); wait_idle("disp");
        bus_op(1'b0, 1'b0, 8'h06, 1); wait_idle("entry");
        bus_op(1'b0, 1'b0, 8'h80, 3); wait_idle("ddaddr");
        bus_op(1'b1, 1'b0, 8'h41, 1); wait_idle("data0");
        bus_op(1'b1, 1'b0, 8'h42, 1); wait_idle("data1");
        peek_addr = 7'd0; #1;
        tests++;
        if (peek_data !== 8'h41) begin fails++; $display("FAIL cfg_peek0: got %02h expected 41", peek_data); end
        peek_addr = 7'd1; #1;
        tests++;
        if (peek_data !== 8'h42) begin fails++; $display("FAIL cfg_peek1: got %02h expected 42", peek_data); end
        tests++;
        if (ac !== 7'd2 || func !== 3'b111 || disp_ctrl !== 3'b100) begin
            fails++;
            $display("FAIL cfg_regs: ac=%02h func=%0h disp=%0h expected 02/7/4", ac, func, disp_ctrl);
        end
    endtask

    task automatic test_busy_err();
        bus_op(1'b1, 1'b0, 8'h55, 1);
        repeat (4) @(posedge clk);
        bus_op(1'b0, 1'b1, 8'h00, 1);
        bus_op(1'b1, 1'b0, 8'h66, 1);
        tests++;
        if (err !== 1'b1 || ac !== 7'd3) begin
            fails++;
            $display("FAIL busy_write: err=%0b ac=%02h expected 1/03", err, ac);
        end
        peek_addr = 7'd3; #1;
        tests++;
        if (peek_data !== 8'h20) begin fails++; $display("FAIL busy_ddram: got %02h expected 20", peek_data); end
        wait_idle("busy_err");
    endtask

    task automatic test_wrap();
        bus_op(1'b0, 1'b0, 8'hFF, 1); wait_idle("addr7f");
        bus_op(1'b1, 1'b0, 8'h55, 1);
        tests++;
        if (ac !== 7'h00) begin fails++; $display("FAIL wrap_up: ac=%02h expected 00", ac); end
        wait_idle("wrap_up");
        bus_op(1'b0, 1'b0, 8'h04, 1); wait_idle("entry_dec");
        bus_op(1'b1, 1'b0, 8'h77, 1);
        tests++;
        if (ac !== 7'h7F) begin fails++; $display("FAIL wrap_down: ac=%02h expected 7f", ac); end
        wait_idle("wrap_down");
    endtask

    task automatic test_clear();
        bus_op(1'b0, 1'b0, 8'h01, 1);
        wait_idle("clear");
        peek_all("clear");
        tests++;
        if (ac !== 7'd0 || entry[1] !== 1'b1) begin
            fails++;
            $display("FAIL clear_regs: ac=%02h entry=%0h expected 00/1x", ac, entry);
        end
    endtask

    task automatic test_random();
        int op;
        logic [7:0] d;
        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            case (op)
                0: bus_op(1'b1, 1'b0, d, int'($urandom_range(1, 3)));
                1: bus_op(1'b0, 1'b0, (d < 8'd4) ? (d + 8'd4) : d, int'($urandom_range(1, 3)));
                2: bus_op(1'b0, 1'b1, d, int'($urandom_range(1, 3)));
                default: bus_op(1'b1, 1'b1, d, int'($urandom_range(1, 3)));
            endcase
            if ($urandom_range(0, 4) == 0) wait_idle("random");
            else repeat (int'($urandom_range(0, 50))) @(posedge clk);
        end
        wait_idle("random_end");
        peek_all("random");
    endtask

    task automatic test_reset_mid_clear();
        bus_op(1'b0, 1'b0, 8'hF0, 1); wait_idle("addr70");
        bus_op(1'b1, 1'b0, 8'h5A, 1); wait_idle("data70");
        bus_op(1'b0, 1'b0, 8'h0F, 1); wait_idle("disp_on");
        bus_op(1'b0, 1'b0, 8'h01, 1);
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if (ac !== 7'd0 || disp_ctrl !== 3'd0 || entry !== 2'b10 || func !== 3'b100 ||
            err !== 1'b0 || wr_stb !== 1'b0 || bf !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: ac=%02h disp=%0h entry=%0h func=%0h err=%0b wr_stb=%0b bf=%0b",
                     ac, disp_ctrl, entry, func, err, wr_stb, bf);
        end
        do_reset();
        wait_idle("por_rerun");
        peek_all("por_rerun");
    endtask

    initial begin
        test_reset();
        test_por();
        test_config();
        test_busy_err();
        test_wrap();
        test_clear();
        test_random();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
